// File: rtl/axil_bridge_pkg.sv
// Shared types and helpers for the PCIe-to-AXI4-Lite bridge datapaths.
// BAR table field widths, BRESP codes and the BAR address translation.
package axil_bridge_pkg;

  localparam int BAR_BASE_W = 64;
  localparam int BAR_SIZE_W = 8;
  localparam int MAX_BARS   = 6;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  // Base supplies the bits above the aperture, the PCIe address the
  // dword-aligned bits inside it; phy is added last.
  function automatic logic [63:0] bar_xlate(
    input logic [63:0] base,
    input logic [7:0]  size,
    input logic [31:0] addr,
    input logic [63:0] phy
  );
    logic [63:0] mask;
    mask = (64'd1 << size) - 64'd1;
    return phy + ((base & ~mask) |
                  ({32'd0, addr} & mask & ~64'd3));
  endfunction

endpackage

// File: rtl/axil_bar_xlate.sv
// Combinational BAR table lookup and phy_addr offset.
// Shared between the AXI-Lite read and write paths.
module axil_bar_xlate
  import axil_bridge_pkg::*;
#(
  parameter int NUM_BARS = 6,
  parameter logic [BAR_BASE_W*MAX_BARS-1:0] BAR_AXI =
    {MAX_BARS{64'h0}},
  parameter logic [BAR_SIZE_W*MAX_BARS-1:0] BAR_SIZE =
    {MAX_BARS{8'd12}},
  parameter int AW = 48
) (
  input  logic [2:0]    bar_hit,
  input  logic [31:0]   pcie_address,
  input  logic [63:0]   phy_addr,
  output logic [AW-1:0] axi_addr,
  output logic          mapped
);

  logic [63:0] base;
  logic [7:0]  size;

  always_comb begin
    base = '0;
    size = 8'd2;
    for (int i = 0; i < MAX_BARS; i++) begin
      if (bar_hit == 3'(i)) begin
        base = BAR_AXI[BAR_BASE_W*i +: BAR_BASE_W];
        size = BAR_SIZE[BAR_SIZE_W*i +: BAR_SIZE_W];
      end
    end
  end

  assign mapped   = int'(bar_hit) < NUM_BARS;
  assign axi_addr = AW'(bar_xlate(base, size,
                                  pcie_address,
                                  phy_addr));

endmodule

// File: rtl/axil_write_engine.sv
// PCIe memory-write to AXI4-Lite write engine with independent AW/W
// issue, multiple writes in flight, BRESP error and B timeout status.
module axil_write_engine
  import axil_bridge_pkg::*;
#(
  parameter int TCQ               = 1,
  parameter int M_AXI_TDATA_WIDTH = 64,
  parameter int M_AXI_ADDR_WIDTH  = 48,
  parameter int NUM_BARS          = 6,
  parameter logic [BAR_BASE_W*MAX_BARS-1:0] BAR_AXI =
    {MAX_BARS{64'h0}},
  parameter logic [BAR_SIZE_W*MAX_BARS-1:0] BAR_SIZE =
    {MAX_BARS{8'd12}},
  parameter int MAX_OUTSTANDING   = 4,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                           m_axi_aclk,
  input  logic                           m_axi_aresetn,
  output logic [M_AXI_ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [2:0]                     m_axi_awprot,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [M_AXI_TDATA_WIDTH-1:0]   m_axi_wdata,
  output logic [M_AXI_TDATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  input  logic                           mem_req_valid,
  output logic                           mem_req_ready,
  input  logic [2:0]                     mem_req_bar_hit,
  input  logic [31:0]                    mem_req_pcie_address,
  input  logic [M_AXI_TDATA_WIDTH/8-1:0] mem_req_byte_enable,
  input  logic                           mem_req_write_readn,
  input  logic [M_AXI_TDATA_WIDTH-1:0]   mem_req_write_data,
  input  logic [63:0]                    phy_addr,
  output logic [3:0]                     outstanding,
  output logic                           err_pulse,
  output logic [15:0]                    err_count,
  output logic                           unmapped_pulse,
  output logic                           timeout,
  input  logic                           status_clear
);

  localparam int AW = M_AXI_ADDR_WIDTH;

  if (TCQ < 0 ||
      (M_AXI_TDATA_WIDTH != 32 && M_AXI_TDATA_WIDTH != 64) ||
      NUM_BARS < 1 || NUM_BARS > MAX_BARS ||
      MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
      TIMEOUT_CYCLES < 0) begin : g_param_err
    $error("axil_write_engine: illegal parameter set");
  end

  logic          aw_pend;
  logic          w_pend;
  logic [AW-1:0] xaddr;
  logic          mapped;
  logic          acc;
  logic          b_hs;
  logic          b_err;
  logic          tmo_hit;
  logic [31:0]   tcnt;

  axil_bar_xlate #(
    .NUM_BARS (NUM_BARS),
    .BAR_AXI  (BAR_AXI),
    .BAR_SIZE (BAR_SIZE),
    .AW       (AW)
  ) u_xlate (
    .bar_hit      (mem_req_bar_hit),
    .pcie_address (mem_req_pcie_address),
    .phy_addr     (phy_addr),
    .axi_addr     (xaddr),
    .mapped       (mapped)
  );

  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = aw_pend;
  assign m_axi_wvalid  = w_pend;
  assign m_axi_bready  = outstanding != 4'd0;

  // Held low in reset so the bridge never sees a spurious ready.
  assign mem_req_ready = m_axi_aresetn & !aw_pend & !w_pend &
                         (outstanding < 4'(MAX_OUTSTANDING)) &
                         !timeout;

  assign acc   = mem_req_valid & mem_req_ready &
                 mem_req_write_readn;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign b_err = b_hs & (m_axi_bresp != BRESP_OKAY);

  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (outstanding != 4'd0) && !b_hs &&
                   (tcnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      aw_pend      <= 1'b0;
      w_pend       <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
    end else if (acc && mapped) begin
      aw_pend      <= 1'b1;
      w_pend       <= 1'b1;
      m_axi_awaddr <= xaddr;
      m_axi_wdata  <= mem_req_write_data;
      m_axi_wstrb  <= mem_req_byte_enable;
    end else begin
      if (aw_pend && m_axi_awready) aw_pend <= 1'b0;
      if (w_pend && m_axi_wready)   w_pend  <= 1'b0;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      outstanding <= 4'd0;
      tcnt        <= 32'd0;
      timeout     <= 1'b0;
    end else begin
      if (tmo_hit)
        outstanding <= 4'd0;
      else if (acc && mapped && !b_hs)
        outstanding <= outstanding + 4'd1;
      else if (b_hs && !(acc && mapped))
        outstanding <= outstanding - 4'd1;

      if (outstanding == 4'd0 || b_hs || tmo_hit)
        tcnt <= 32'd0;
      else if (TIMEOUT_CYCLES != 0)
        tcnt <= tcnt + 32'd1;

      if (status_clear)
        timeout <= 1'b0;
      else if (tmo_hit)
        timeout <= 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      err_pulse      <= 1'b0;
      err_count      <= 16'd0;
      unmapped_pulse <= 1'b0;
    end else begin
      err_pulse      <= b_err;
      unmapped_pulse <= acc & !mapped;
      if (status_clear)
        err_count <= 16'd0;
      else if (b_err && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axil_write_engine.sv
// Directed bench for axil_write_engine: translation, pipelining,
// channel skew, errors, unmapped BARs, timeout and reset.
module tb_axil_write_engine;

  localparam int DW = 64;
  localparam int AW = 48;
  localparam int SW = DW / 8;

  localparam logic [64*6-1:0] BARS = {
    64'h0, 64'h0,
    64'h0000_FFFF_FFFF_F000,
    64'h0000_ABCD_0000_0000,
    64'h0000_0000_0001_0000,
    64'h0};
  localparam logic [8*6-1:0] SIZES = {
    8'd12, 8'd12, 8'd12, 8'd16, 8'd12, 8'd12};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    bar;
  logic [31:0]   addr;
  logic [SW-1:0] be;
  logic          wrn;
  logic [DW-1:0] wd;
  logic [63:0]   phy;
  logic [3:0]    outstanding;
  logic          err_pulse;
  logic [15:0]   err_count;
  logic          unmapped_pulse;
  logic          timeout;
  logic          status_clear;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axil_write_engine #(
    .TCQ               (1),
    .M_AXI_TDATA_WIDTH (DW),
    .M_AXI_ADDR_WIDTH  (AW),
    .NUM_BARS          (6),
    .BAR_AXI           (BARS),
    .BAR_SIZE          (SIZES),
    .MAX_OUTSTANDING   (4),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .m_axi_aclk           (clk),
    .m_axi_aresetn        (rst_n),
    .m_axi_awaddr         (awaddr),
    .m_axi_awprot         (awprot),
    .m_axi_awvalid        (awvalid),
    .m_axi_awready        (awready),
    .m_axi_wdata          (wdata),
    .m_axi_wstrb          (wstrb),
    .m_axi_wvalid         (wvalid),
    .m_axi_wready         (wready),
    .m_axi_bresp          (bresp),
    .m_axi_bvalid         (bvalid),
    .m_axi_bready         (bready),
    .mem_req_valid        (req_valid),
    .mem_req_ready        (req_ready),
    .mem_req_bar_hit      (bar),
    .mem_req_pcie_address (addr),
    .mem_req_byte_enable  (be),
    .mem_req_write_readn  (wrn),
    .mem_req_write_data   (wd),
    .phy_addr             (phy),
    .outstanding          (outstanding),
    .err_pulse            (err_pulse),
    .err_count            (err_count),
    .unmapped_pulse       (unmapped_pulse),
    .timeout              (timeout),
    .status_clear         (status_clear)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] b,
                     input logic [31:0] a,
                     input logic [DW-1:0] d,
                     input logic [SW-1:0] e);
    req_valid = 1'b1;
    bar  = b;
    addr = a;
    wd   = d;
    be   = e;
    wrn  = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0;  bresp = 2'b00;
    req_valid = 1'b0; bar = 3'd0; addr = '0;
    be = '0; wrn = 1'b1; wd = '0; phy = '0;
    status_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("awprot", 64'(awprot), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 64'(req_ready), 64'd1);

    // single write through BAR1
    awready = 1'b1; wready = 1'b1;
    req(3'd1, 32'h0000_0A37, 64'h1122_3344_5566_7788, 8'hF0);
    chk("sw_awvalid", 64'(awvalid), 64'd1);
    chk("sw_wvalid", 64'(wvalid), 64'd1);
    chk("sw_awaddr", 64'(awaddr), 64'h1_0A34);
    chk("sw_wdata", wdata, 64'h1122_3344_5566_7788);
    chk("sw_wstrb", 64'(wstrb), 64'hF0);
    chk("sw_outst", 64'(outstanding), 64'd1);
    chk("sw_ready_busy", 64'(req_ready), 64'd0);
    step();
    chk("sw_aw_done", 64'(awvalid), 64'd0);
    chk("sw_ready", 64'(req_ready), 64'd1);
    chk("sw_bready", 64'(bready), 64'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("sw_b_outst", 64'(outstanding), 64'd0);
    chk("sw_b_bready", 64'(bready), 64'd0);

    // pipelining up to the outstanding limit
    req_valid = 1'b1; bar = 3'd1; addr = 32'h100;
    repeat (8) step();
    chk("pl_outst4", 64'(outstanding), 64'd4);
    chk("pl_ready0", 64'(req_ready), 64'd0);
    bvalid = 1'b1;
    step();
    chk("pl_outst3", 64'(outstanding), 64'd3);
    chk("pl_ready1", 64'(req_ready), 64'd1);
    step();
    bvalid = 1'b0;
    chk("pl_acc_b_out", 64'(outstanding), 64'd3);
    chk("pl_acc5_aw", 64'(awvalid), 64'd1);
    step();
    step();
    req_valid = 1'b0;
    chk("pl_acc6_out", 64'(outstanding), 64'd4);
    step();
    bvalid = 1'b1;
    repeat (4) step();
    bvalid = 1'b0;
    chk("pl_drain", 64'(outstanding), 64'd0);

    // W completes well before AW
    awready = 1'b0; wready = 1'b1;
    req(3'd2, 32'h1234_5678, 64'hA5A5, 8'h0F);
    chk("sk_awaddr", 64'(awaddr), 64'hABCD_0000_5678);
    req_valid = 1'b1; addr = 32'h0;
    step();
    chk("sk_w_drop", 64'(wvalid), 64'd0);
    chk("sk_aw_hold", 64'(awvalid), 64'd1);
    repeat (4) step();
    chk("sk_aw_hold2", 64'(awvalid), 64'd1);
    chk("sk_awaddr_st", 64'(awaddr), 64'hABCD_0000_5678);
    chk("sk_no_acc", 64'(outstanding), 64'd1);
    awready = 1'b1;
    step();
    chk("sk_aw_done", 64'(awvalid), 64'd0);
    chk("sk_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    chk("sk_next_acc", 64'(outstanding), 64'd2);
    step();
    bvalid = 1'b1;
    repeat (2) step();
    bvalid = 1'b0;
    chk("sk_drain", 64'(outstanding), 64'd0);

    // AW completes before W; address wraps past 48 bits
    awready = 1'b1; wready = 1'b0;
    phy = 64'h2000;
    req(3'd3, 32'h0000_0004, 64'h0BAD_F00D, 8'h3C);
    phy = 64'h0;
    step();
    chk("rs_aw_drop", 64'(awvalid), 64'd0);
    chk("rs_w_hold", 64'(wvalid), 64'd1);
    chk("rs_awaddr", 64'(awaddr), 64'h1004);
    repeat (4) step();
    chk("rs_w_hold2", 64'(wvalid), 64'd1);
    chk("rs_wdata_st", wdata, 64'h0BAD_F00D);
    chk("rs_ready0", 64'(req_ready), 64'd0);
    wready = 1'b1;
    step();
    chk("rs_w_done", 64'(wvalid), 64'd0);
    chk("rs_ready1", 64'(req_ready), 64'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;

    // BRESP errors
    req_valid = 1'b1; bar = 3'd1;
    repeat (6) step();
    req_valid = 1'b0;
    chk("er_outst3", 64'(outstanding), 64'd3);
    bvalid = 1'b1; bresp = 2'b10;
    step();
    chk("er_pulse1", 64'(err_pulse), 64'd1);
    chk("er_cnt1", 64'(err_count), 64'd1);
    bresp = 2'b00;
    step();
    chk("er_pulse_ok", 64'(err_pulse), 64'd0);
    chk("er_cnt_ok", 64'(err_count), 64'd1);
    bresp = 2'b11;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("er_pulse2", 64'(err_pulse), 64'd1);
    chk("er_cnt2", 64'(err_count), 64'd2);
    step();
    chk("er_pulse_end", 64'(err_pulse), 64'd0);
    status_clear = 1'b1;
    step();
    status_clear = 1'b0;
    chk("er_clear", 64'(err_count), 64'd0);
    req(3'd1, 32'h8, 64'h1, 8'h01);
    step();
    bvalid = 1'b1; bresp = 2'b10; status_clear = 1'b1;
    step();
    bvalid = 1'b0; bresp = 2'b00; status_clear = 1'b0;
    chk("er_clr_wins", 64'(err_count), 64'd0);

    // unmapped BAR and ignored read
    req(3'd6, 32'h40, 64'h2, 8'hFF);
    chk("um_pulse", 64'(unmapped_pulse), 64'd1);
    chk("um_no_aw", 64'(awvalid), 64'd0);
    chk("um_outst", 64'(outstanding), 64'd0);
    step();
    chk("um_pulse_end", 64'(unmapped_pulse), 64'd0);
    req_valid = 1'b1; wrn = 1'b0; bar = 3'd1;
    step();
    req_valid = 1'b0; wrn = 1'b1;
    chk("rd_no_aw", 64'(awvalid), 64'd0);
    chk("rd_outst", 64'(outstanding), 64'd0);

    // B timeout
    req(3'd1, 32'h10, 64'h3, 8'hFF);
    repeat (15) step();
    chk("to_not_yet", 64'(timeout), 64'd0);
    chk("to_outst1", 64'(outstanding), 64'd1);
    step();
    chk("to_set", 64'(timeout), 64'd1);
    chk("to_outst0", 64'(outstanding), 64'd0);
    chk("to_ready0", 64'(req_ready), 64'd0);
    chk("to_bready0", 64'(bready), 64'd0);
    status_clear = 1'b1;
    step();
    status_clear = 1'b0;
    chk("to_clear", 64'(timeout), 64'd0);
    chk("to_ready1", 64'(req_ready), 64'd1);

    // reset in the middle of a write
    awready = 1'b0; wready = 1'b0;
    req(3'd1, 32'h20, 64'h4, 8'hFF);
    chk("mr_pre_aw", 64'(awvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_awvalid", 64'(awvalid), 64'd0);
    chk("mr_wvalid", 64'(wvalid), 64'd0);
    chk("mr_outst", 64'(outstanding), 64'd0);
    step();
    rst_n = 1'b1;
    bvalid = 1'b1; bresp = 2'b10;
    repeat (2) step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("mr_late_b", 64'(err_count), 64'd0);
    chk("mr_late_out", 64'(outstanding), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
